core_ctrl: RTL

//  Multi-cycle control FSM for the RV32I core. It is the producer side of the ALU control

---
 rtl/core_pkg.sv | 58 +++++
 rtl/core_ctrl_if.sv | 41 ++++
 rtl/core_decode.sv | 64 ++++++
 rtl/core_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
package core_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  // ALU control as understood by alu32; Sleft exists there but this core never issues it.
  typedef enum logic [1:0] {
    AluAdd    = 2'd0,
    AluSleft  = 2'd1,
    AluBranch = 2'd2,
    AluFunct  = 2'd3
  } aluop_e;

  typedef enum logic [1:0] {ASelRs1 = 2'd0, ASelPc = 2'd1, ASelZero = 2'd2} asel_e;
  typedef enum logic       {BSelRs2 = 1'b0, BSelImm = 1'b1} bsel_e;
  typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2} wbsel_e;
  typedef enum logic       {PcSelPc4 = 1'b0, PcSelTarget = 1'b1} pcsel_e;

  // Coarse instruction class; selects the FSM path after Exec.
  typedef enum logic [2:0] {
    ClsAlu    = 3'd0,
    ClsBranch = 3'd1,
    ClsJump   = 3'd2,
    ClsLoad   = 3'd3,
    ClsStore  = 3'd4
  } iclass_e;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StFetchWait = 3'd1,
    StDecode    = 3'd2,
    StExec      = 3'd3,
    StMemReq    = 3'd4,
    StMemWait   = 3'd5,
    StWb        = 3'd6,
    StTrap      = 3'd7
  } state_e;

  typedef struct packed {
    aluop_e  aluop;
    asel_e   a_sel;
    bsel_e   b_sel;
    wbsel_e  wb_sel;
    iclass_e cls;
    logic    illegal;
  } dec_s;

endpackage

// File: rtl/core_ctrl_if.sv
// Control-path bus: memory handshakes, ALU control and datapath strobes/selects.
interface core_ctrl_if;
  import core_pkg::*;

  logic        imem_req_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] instr_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic        zero_i;
  aluop_e      aluop_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic        itype_o;
  asel_e       a_sel_o;
  bsel_e       b_sel_o;
  logic        ir_we_o;
  logic        rf_we_o;
  wbsel_e      wb_sel_o;
  logic        pc_we_o;
  pcsel_e      pc_sel_o;
  logic        trap_o;

  // Controller side.
  modport master (
    output imem_req_o, dmem_req_o, dmem_we_o, aluop_o, funct3_o, funct7_o, itype_o,
           a_sel_o, b_sel_o, ir_we_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, trap_o,
    input  imem_gnt_i, imem_rvalid_i, instr_i, dmem_gnt_i, dmem_rvalid_i, zero_i
  );

  // Memory / datapath side.
  modport slave (
    input  imem_req_o, dmem_req_o, dmem_we_o, aluop_o, funct3_o, funct7_o, itype_o,
           a_sel_o, b_sel_o, ir_we_o, rf_we_o, wb_sel_o, pc_we_o, pc_sel_o, trap_o,
    output imem_gnt_i, imem_rvalid_i, instr_i, dmem_gnt_i, dmem_rvalid_i, zero_i
  );

endinterface

// File: rtl/core_decode.sv
// Combinational opcode decoder: ALU control, operand selects, writeback source, class.
module core_decode
  import core_pkg::*;
(
  input  logic [6:0] i_opcode,
  output dec_s       o_dec
);

  // Map each RV32I base opcode onto its control pattern; anything else is illegal.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned (no latch).
    o_dec.aluop   = AluAdd;
    o_dec.a_sel   = ASelRs1;
    o_dec.b_sel   = BSelRs2;
    o_dec.wb_sel  = WbAlu;
    o_dec.cls     = ClsAlu;
    o_dec.illegal = 1'b0;
    case (i_opcode)
      OpOp: begin
        o_dec.aluop = AluFunct;
      end
      OpImm: begin
        o_dec.aluop = AluFunct;
        o_dec.b_sel = BSelImm;
      end
      OpBranch: begin
        o_dec.aluop = AluBranch;
        o_dec.cls   = ClsBranch;
      end
      OpLoad: begin
        o_dec.b_sel  = BSelImm;
        o_dec.wb_sel = WbMem;
        o_dec.cls    = ClsLoad;
      end
      OpStore: begin
        o_dec.b_sel = BSelImm;
        o_dec.cls   = ClsStore;
      end
      OpJalr: begin
        o_dec.b_sel  = BSelImm;
        o_dec.wb_sel = WbPc4;
        o_dec.cls    = ClsJump;
      end
      OpJal: begin
        o_dec.a_sel  = ASelPc;
        o_dec.b_sel  = BSelImm;
        o_dec.wb_sel = WbPc4;
        o_dec.cls    = ClsJump;
      end
      OpAuipc: begin
        o_dec.a_sel = ASelPc;
        o_dec.b_sel = BSelImm;
      end
      OpLui: begin
        o_dec.a_sel = ASelZero;
        o_dec.b_sel = BSelImm;
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback sequencing.
module core_ctrl
  import core_pkg::*;
#(
  parameter bit HaltOnIllegal = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  core_ctrl_if.master      bus
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_ir;
  dec_s        w_dec;

  aluop_e      r_aluop;
  asel_e       r_a_sel;
  bsel_e       r_b_sel;
  wbsel_e      r_wb_sel;
  iclass_e     r_cls;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic        r_itype;
  logic        r_rd_nz;
  logic        r_trap;

  // rs1/rs2 fields feed the register file in the datapath, not this controller.
  logic        w_unused_ir;
  assign w_unused_ir = ^r_ir[24:15];

  core_decode u_decode (
    .i_opcode (r_ir[6:0]),
    .o_dec    (w_dec)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) r_state <= StFetch;
    else       r_state <= w_next_state;
  end

  // Controller's own copy of the instruction, loaded on the same strobe as the datapath IR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                              r_ir <= NopInstr;
    else if (r_state == StFetchWait && bus.imem_rvalid_i)   r_ir <= instr_i_w();
  end

  function automatic logic [31:0] instr_i_w();
    return bus.instr_i;
  endfunction

  // Decoded controls captured in Decode, held unchanged through Exec..Wb.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aluop  <= AluAdd;
      r_a_sel  <= ASelRs1;
      r_b_sel  <= BSelRs2;
      r_wb_sel <= WbAlu;
      r_cls    <= ClsAlu;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_itype  <= 1'b0;
      r_rd_nz  <= 1'b0;
    end else if (r_state == StDecode) begin
      r_aluop  <= w_dec.aluop;
      r_a_sel  <= w_dec.a_sel;
      r_b_sel  <= w_dec.b_sel;
      r_wb_sel <= w_dec.wb_sel;
      r_cls    <= w_dec.cls;
      r_funct3 <= r_ir[14:12];
      r_funct7 <= r_ir[31:25];
      r_itype  <= (r_ir[6:0] == OpImm);
      // An illegal word falling through as a NOP must not write the register file.
      r_rd_nz  <= (r_ir[11:7] != 5'd0) && !w_dec.illegal;
    end
  end

  // Sticky illegal-instruction flag; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    r_trap <= 1'b0;
    else if (r_state == StDecode && w_dec.illegal) r_trap <= 1'b1;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      StFetch:     if (bus.imem_gnt_i)    w_next_state = StFetchWait;
      StFetchWait: if (bus.imem_rvalid_i) w_next_state = StDecode;
      StDecode: begin
        if (!w_dec.illegal)    w_next_state = StExec;
        else if (HaltOnIllegal) w_next_state = StTrap;
        else                    w_next_state = StWb;
      end
      StExec: begin
        case (r_cls)
          ClsBranch:         w_next_state = StFetch;
          ClsLoad, ClsStore: w_next_state = StMemReq;
          default:           w_next_state = StWb;
        endcase
      end
      StMemReq:  if (bus.dmem_gnt_i) w_next_state = StMemWait;
      StMemWait: begin
        if (bus.dmem_rvalid_i) w_next_state = (r_cls == ClsStore) ? StFetch : StWb;
      end
      StWb:      w_next_state = StFetch;
      StTrap:    w_next_state = StTrap;
      default:   w_next_state = StFetch;
    endcase
  end

  // Output logic: strobes/requests from state (and handshake inputs), selects from registers.
  always_comb begin
    bus.imem_req_o = 1'b0;
    bus.ir_we_o    = 1'b0;
    bus.dmem_req_o = 1'b0;
    bus.dmem_we_o  = 1'b0;
    bus.rf_we_o    = 1'b0;
    bus.pc_we_o    = 1'b0;
    bus.pc_sel_o   = PcSelPc4;
    bus.aluop_o    = r_aluop;
    bus.funct3_o   = r_funct3;
    bus.funct7_o   = r_funct7;
    bus.itype_o    = r_itype;
    bus.a_sel_o    = r_a_sel;
    bus.b_sel_o    = r_b_sel;
    bus.wb_sel_o   = r_wb_sel;
    bus.trap_o     = r_trap;
    case (r_state)
      // Held off while reset is asserted so the fetch starts only after release.
      StFetch:     bus.imem_req_o = !rst_i;
      StFetchWait: bus.ir_we_o    = bus.imem_rvalid_i;
      StExec: begin
        if (r_cls == ClsBranch) begin
          bus.pc_we_o  = 1'b1;
          bus.pc_sel_o = bus.zero_i ? PcSelTarget : PcSelPc4;
        end else if (r_cls == ClsJump) begin
          bus.pc_we_o  = 1'b1;
          bus.pc_sel_o = PcSelTarget;
        end
      end
      StMemReq: begin
        bus.dmem_req_o = 1'b1;
        bus.dmem_we_o  = (r_cls == ClsStore);
      end
      StMemWait: begin
        bus.pc_we_o = bus.dmem_rvalid_i && (r_cls == ClsStore);
      end
      StWb: begin
        bus.rf_we_o = r_rd_nz;
        // Jumps already redirected the PC in Exec.
        bus.pc_we_o = (r_cls != ClsJump);
      end
      default: ;
    endcase
  end

endmodule
